// File: rtl/mem_host_ctrl_pkg.sv
// Shared types and defaults for the memory host controller and its RAMs.
// Build option MEM_HOST_TIMEOUT_EN adds the RUN-phase watchdog.
package mem_host_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF     = 8;
    localparam int DATA_WIDTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_DUMP   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // One extra bit so a phase counter can reach the full depth without wrapping.
    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/mem_host_ctrl_if.sv
// Host load/dump streams plus the processor's IM/DM ports and start/stop.
// master = host + processor side, slave = mem_host_ctrl.
interface mem_host_ctrl_if
    import mem_host_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic                  dp_valid;
    logic [DATA_WIDTH-1:0] dp_data;
    logic                  dp_ready;
    logic                  start;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic                  im_rd;
    logic [DATA_WIDTH-1:0] im_r_data;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic                  dm_rd;
    logic                  dm_wr;
    logic [DATA_WIDTH-1:0] dm_w_data;
    logic [DATA_WIDTH-1:0] dm_r_data;

    modport master (
        output ld_valid, ld_data, dp_ready, stop,
        output im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
        input  ld_ready, dp_valid, dp_data, start, im_r_data, dm_r_data
    );

    modport slave (
        input  ld_valid, ld_data, dp_ready, stop,
        input  im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
        output ld_ready, dp_valid, dp_data, start, im_r_data, dm_r_data
    );
endinterface

// File: rtl/mem_host_ram.sv
// 1W1R synchronous RAM; a read and write to the same address on one edge
// returns the old word. Only the read register is reset, never the array.
module mem_host_ram
    import mem_host_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mem_host_ctrl.sv
// Owns IM/DM for the processor and sequences clear -> load -> run -> dump.
// Define MEM_HOST_TIMEOUT_EN to add a RUN watchdog (TIMEOUT_CYCLES).
module mem_host_ctrl
    import mem_host_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LOAD_LEN   = 256,
    parameter int DUMP_LEN   = 256
`ifdef MEM_HOST_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    mem_host_ctrl_if.slave bus
);
    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] CLEAR_LAST = CW'((1 << ADDR_WIDTH) - 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_LEN - 1);
    localparam logic [CW-1:0] DUMP_END   = CW'(DUMP_LEN);

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  start_q, start_nx;
    logic                  dp_valid_q, dp_valid_nx;
    logic                  ld_fire, dp_take, dump_fetch, run_stop, run_expired;
    logic                  dm_we, dm_re;
    logic [ADDR_WIDTH-1:0] dm_waddr, dm_raddr;
    logic [DATA_WIDTH-1:0] dm_wdata, im_q, dm_q;

    assign ld_fire  = (state == ST_LOAD) && bus.ld_valid;
    assign dp_take  = dp_valid_q && bus.dp_ready;
    // stop on the first RUN cycle (start still high) is left over from the last run
    assign run_stop = (state == ST_RUN) && bus.stop && !start_q;
    // Refill the single output word whenever it is empty or being accepted.
    assign dump_fetch = (state == ST_DUMP) && (cnt != DUMP_END) && (!dp_valid_q || bus.dp_ready);

`ifdef MEM_HOST_TIMEOUT_EN
    localparam int RW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT_CYCLES - 1);
    logic [RW-1:0] run_cnt;
    logic          timeout_q;

    always_ff @(posedge clk) begin
        if (rst || state != ST_RUN) run_cnt <= '0;
        else                        run_cnt <= run_cnt + RW'(1);
    end

    assign run_expired = (state == ST_RUN) && (run_cnt == RUN_LAST);

    always_ff @(posedge clk) begin
        if (rst)                               timeout_q <= 1'b0;
        else if (state == ST_IDLE && go)       timeout_q <= 1'b0;
        else if (run_expired && !run_stop)     timeout_q <= 1'b1;
    end

    assign timeout = timeout_q;
`else
    assign run_expired = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            start_q    <= 1'b0;
            dp_valid_q <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            start_q    <= start_nx;
            dp_valid_q <= dp_valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        start_nx    = 1'b0;
        dp_valid_nx = dp_valid_q;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == CLEAR_LAST) begin
                    state_nx = ST_LOAD;
                    cnt_nx   = '0;
                end
            end
            ST_LOAD: begin
                if (ld_fire) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == LOAD_LAST) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                        start_nx = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (run_stop || run_expired) begin
                    state_nx = ST_DUMP;
                    cnt_nx   = '0;
                end
            end
            ST_DUMP: begin
                if (dump_fetch) begin
                    cnt_nx      = cnt + CW'(1);
                    dp_valid_nx = 1'b1;
                end else if (dp_take) begin
                    dp_valid_nx = 1'b0;
                    if (cnt == DUMP_END) state_nx = ST_FINISH;
                end
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // DM port muxing: CLEAR owns the write port, processor writes only count in
    // RUN; the dump sequencer takes the read port during DUMP.
    always_comb begin
        dm_we    = 1'b0;
        dm_waddr = bus.dm_addr;
        dm_wdata = bus.dm_w_data;
        dm_re    = bus.dm_rd;
        dm_raddr = bus.dm_addr;
        if (state == ST_CLEAR) begin
            dm_we    = 1'b1;
            dm_waddr = cnt[ADDR_WIDTH-1:0];
            dm_wdata = '0;
        end else if (state == ST_RUN) begin
            dm_we = bus.dm_wr;
        end
        if (state == ST_DUMP) begin
            dm_re    = dump_fetch;
            dm_raddr = cnt[ADDR_WIDTH-1:0];
        end
    end

    mem_host_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_im (
        .clk   (clk),
        .rst   (rst),
        .we    (ld_fire),
        .waddr (cnt[ADDR_WIDTH-1:0]),
        .wdata (bus.ld_data),
        .re    (bus.im_rd),
        .raddr (bus.im_addr),
        .rdata (im_q)
    );

    mem_host_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dm (
        .clk   (clk),
        .rst   (rst),
        .we    (dm_we),
        .waddr (dm_waddr),
        .wdata (dm_wdata),
        .re    (dm_re),
        .raddr (dm_raddr),
        .rdata (dm_q)
    );

    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_FINISH);
    assign bus.ld_ready  = (state == ST_LOAD);
    assign bus.start     = start_q;
    assign bus.dp_valid  = dp_valid_q;
    assign bus.dp_data   = dm_q;
    assign bus.dm_r_data = dm_q;
    assign bus.im_r_data = im_q;
endmodule

// File: tb/tb_mem_host_ctrl.sv
// Directed run sequence with randomized program/data/handshakes, checked
// against an array model of IM/DM and the phase timing rules.
module tb_mem_host_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int LL    = 4;
    localparam int DL    = 16;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst, go, busy, done, timeout;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] dm_m [DEPTH];
    logic [DW-1:0] prog [LL];
    int            lat, last_a;

    mem_host_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_host_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOAD_LEN   (LL),
        .DUMP_LEN   (DL)
`ifdef MEM_HOST_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        go            = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.dp_ready  = 1'b0;
        bus.stop      = 1'b0;
        bus.im_addr   = '0;
        bus.im_rd     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_rd     = 1'b0;
        bus.dm_wr     = 1'b0;
        bus.dm_w_data = '0;
    endtask

    // go -> CLEAR -> LOAD (with random ld_valid gaps) -> first RUN cycle.
    // Returns one cycle after the start pulse (second RUN cycle).
    task automatic run_to_start(input int gap_pct, input bit stale_stop);
        int n, gaps, k;
        for (int i = 0; i < DEPTH; i++) dm_m[i] = '0;
        for (int i = 0; i < LL; i++) prog[i] = DW'($urandom);
        bus.stop = stale_stop;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("busy_clear", busy, 1);
        check("ld_ready_clear", bus.ld_ready, 0);
        n = 0; gaps = 0; k = 0;
        while (!bus.start && n < 2000) begin
            bus.ld_valid = 1'b0;
            if (bus.ld_ready && k < LL) begin
                if (int'($urandom_range(99)) < gap_pct) gaps++;
                else begin
                    bus.ld_valid = 1'b1;
                    bus.ld_data  = prog[k];
                    k++;
                end
            end
            tick();
            n++;
        end
        bus.ld_valid = 1'b0;
        check("start_latency", n, DEPTH + LL + gaps);
        tick();
        check("start_pulse", bus.start, 0);
        check("dp_valid_run", bus.dp_valid, 0);
    endtask

    task automatic im_check();
        for (int k = 0; k < LL; k++) begin
            bus.im_addr = AW'(k);
            bus.im_rd   = 1'b1;
            tick();
            check("im_read", bus.im_r_data, prog[k]);
        end
        bus.im_rd   = 1'b0;
        bus.im_addr = '0;
        tick();
        check("im_hold", bus.im_r_data, prog[LL-1]);
    endtask

    task automatic proc_write(input int a, input logic [DW-1:0] d);
        bus.dm_wr     = 1'b1;
        bus.dm_rd     = 1'b1;
        bus.dm_addr   = AW'(a);
        bus.dm_w_data = d;
        tick();
        check("rw_old_data", bus.dm_r_data, dm_m[a]);
        dm_m[a]   = d;
        last_a    = a;
        bus.dm_wr = 1'b0;
        bus.dm_rd = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.dp_valid && n < 64) begin
            tick();
            n++;
        end
    endtask

    // mode 0: dp_ready always high; mode 1: 1-0-0-1 then random.
    // abort > 0 returns once that many words have been accepted.
    task automatic do_dump(input int mode, input int abort);
        int idx, cyc, done_cnt;
        bit stall, rdy;
        logic [DW-1:0] held;
        idx = 0; cyc = 0; done_cnt = 0; stall = 0; held = '0;
        while (cyc < 500) begin
            if (done) begin
                done_cnt++;
                break;
            end
            if (abort > 0 && idx == abort) break;
            if (mode == 0)    rdy = 1'b1;
            else if (cyc < 8) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            else              rdy = 1'($urandom_range(1));
            if (bus.dp_valid) begin
                if (stall) check("dp_stable", bus.dp_data, held);
                if (rdy) begin
                    check("dump_word", bus.dp_data, (idx < DL) ? dm_m[idx] : 16'hxxxx);
                    idx++;
                    stall = 1'b0;
                end else stall = 1'b1;
                held = bus.dp_data;
            end else stall = 1'b0;
            bus.dp_ready = rdy;
            tick();
            cyc++;
        end
        bus.dp_ready = 1'b0;
        if (abort == 0) begin
            check("dump_count", idx, DL);
            check("done_seen", done_cnt, 1);
            if (mode == 0) check("dump_cycles", cyc, DL);
            bus.stop = 1'b0;
            tick();
            check("done_once", done, 0);
            check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        idle_inputs();
        last_a = 0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_dp_valid", bus.dp_valid, 0);
        check("rst_start", bus.start, 0);
        check("rst_im_r_data", bus.im_r_data, 0);
        check("rst_dm_r_data", bus.dm_r_data, 0);
        check("rst_dp_data", bus.dp_data, 0);
        rst = 1'b0;
        tick();

        // Run 1: full load, IM read-back, processor writes incl. DM[5]=BEEF.
        run_to_start(0, 1'b0);
        im_check();
        for (int i = 0; i < 4; i++) proc_write(int'($urandom_range(DL - 1)), DW'($urandom));
        proc_write(5, 16'hBEEF);
        bus.stop = 1'b1;
        wait_valid(lat);
        check("dump_latency", lat, 2);
        do_dump(0, 0);

        // IDLE: processor writes ignored, reads return stored contents.
        bus.dm_wr = 1'b1; bus.dm_addr = 8'd3; bus.dm_w_data = 16'h1234;
        tick();
        bus.dm_wr = 1'b0; bus.dm_rd = 1'b1;
        tick();
        check("idle_wr_ignored", bus.dm_r_data, dm_m[3]);
        bus.dm_addr = 8'd5;
        tick();
        check("idle_rd", bus.dm_r_data, 16'hBEEF);
        bus.dm_rd = 1'b0;

        // Run 2: ld_valid gaps, stale stop, stalled dump.
        run_to_start(30, 1'b1);
        proc_write(int'($urandom_range(DL - 1)), DW'($urandom));
        wait_valid(lat);
        check("stale_stop_latency", lat, 1);
        do_dump(1, 0);

        // Run 3: watchdog (if built) then reset in the middle of the dump.
        run_to_start(0, 1'b0);
        for (int i = 0; i < 3; i++) proc_write(int'($urandom_range(DL - 1)), DW'($urandom));
`ifdef MEM_HOST_TIMEOUT_EN
        lat = 0;
        while (!timeout && lat < 100) begin
            tick();
            lat++;
        end
        check("timeout_cycle", lat, TO - 4);
        check("timeout_dp_valid", bus.dp_valid, 0);
        tick();
        check("timeout_dump", bus.dp_valid, 1);
`else
        bus.stop = 1'b1;
        wait_valid(lat);
        check("dump_latency3", lat, 2);
        check("timeout_tied", timeout, 0);
`endif
        do_dump(0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.stop = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dp_valid", bus.dp_valid, 0);
        check("mid_rst_dp_data", bus.dp_data, 0);
        check("mid_rst_timeout", timeout, 0);
        tick();
        check("post_rst_idle", bus.dp_valid, 0);
        bus.dm_rd = 1'b1; bus.dm_addr = AW'(last_a);
        bus.im_rd = 1'b1; bus.im_addr = 8'd1;
        tick();
        check("dm_kept", bus.dm_r_data, dm_m[last_a]);
        check("im_kept", bus.im_r_data, prog[1]);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_host_ctrl.md
# mem_host_ctrl

Host-side responder for the 16-bit pipelined processor's instruction-memory and data-memory ports. It owns both memories, serves the processor's `im_*`/`dm_*` requests with one-cycle synchronous read latency, and sequences a full run: clear DM, stream a program into IM, pulse `start`, wait for `stop`, then stream DM contents back out. It sits between the testbench/host and the processor top, replacing ad-hoc memory models.

## Interface
- `ADDR_WIDTH`, 8, IM/DM address width; depth = 2^ADDR_WIDTH
- `DATA_WIDTH`, 16, word width
- `LOAD_LEN`, 256, program words accepted per run (1..2^ADDR_WIDTH)
- `DUMP_LEN`, 256, DM words streamed out per run (1..2^ADDR_WIDTH)
- `TIMEOUT_CYCLES`, 4096, RUN watchdog limit (only with `MEM_HOST_TIMEOUT_EN`)

- `clk` in 1 single clock, all logic on rising edge
- `rst` in 1 synchronous, active-high reset
- `go` in 1 host request to begin a run; sampled in IDLE only
- `busy` out 1 high in every state except IDLE
- `done` out 1 one-cycle pulse on DUMP completion
- `timeout` out 1 sticky flag, set on watchdog expiry, cleared on next accepted `go`
- `ld_valid` in 1 program word valid
- `ld_data` in DATA_WIDTH program word
- `ld_ready` out 1 high in LOAD only
- `dp_valid` out 1 dump word valid
- `dp_data` out DATA_WIDTH dump word
- `dp_ready` in 1 host accepts dump word
- `start` out 1 one-cycle pulse to processor
- `stop` in 1 processor halted (level)
- `im_addr` in ADDR_WIDTH; `im_rd` in 1; `im_r_data` out DATA_WIDTH
- `dm_addr` in ADDR_WIDTH; `dm_rd` in 1; `dm_wr` in 1; `dm_w_data` in DATA_WIDTH; `dm_r_data` out DATA_WIDTH

## Operation
- States: IDLE, CLEAR, LOAD, RUN, DUMP, FINISH.
- IDLE: `go`=1 → CLEAR, counter=0, `timeout` cleared.
- CLEAR: writes 0 to DM[counter] each cycle; after address 2^ADDR_WIDTH−1 → LOAD, counter=0.
- LOAD: each `ld_valid && ld_ready` writes IM[counter]=`ld_data`, counter+1; after LOAD_LEN-th word → RUN. IM words at/above LOAD_LEN keep prior contents.
- RUN: `start`=1 on the first RUN cycle only. Processor writes (`dm_wr`) honoured only in RUN. `stop`=1 sampled from the second RUN cycle on → DUMP, counter=0. `stop` high on the first RUN cycle is ignored (stale from previous run).
- DUMP: reads DM[0..DUMP_LEN−1] in order; each word presented on `dp_data` with `dp_valid`=1 and held stable until `dp_ready`. After last accepted word → FINISH.
- FINISH: `done`=1 for one cycle → IDLE.
- Processor reads (`im_rd`, `dm_rd`) served in all states; `dm_rd` outside RUN returns DM contents as-is. `dm_rd` and `dm_wr` same address same cycle: read returns old data.
- `im_rd`=0 / `dm_rd`=0: corresponding read-data register holds its value.
- Counter is ADDR_WIDTH+1 bits; no wrap-around within a phase.

## Timing
- Reset: state=IDLE, counter=0; `busy`,`done`,`timeout`,`ld_ready`,`dp_valid`,`start`=0; `im_r_data`,`dm_r_data`,`dp_data`=0.
- IM/DM read latency 1 cycle: address at edge N → data valid after edge N+1.
- DM write takes effect at the edge where `dm_wr`=1.
- DUMP: first `dp_valid` rises 1 cycle after DUMP entry (read latency); with `dp_ready` held high, one word per cycle thereafter via one-entry read-ahead; DUMP_LEN words take DUMP_LEN+1 cycles.
- CLEAR takes exactly 2^ADDR_WIDTH cycles; LOAD at least LOAD_LEN cycles.
- `rst` mid-run: returns to IDLE next edge, outputs to reset values; memory contents not cleared.

## Configuration
- `MEM_HOST_TIMEOUT_EN` defined: RUN cycle counter; if `stop` not seen within TIMEOUT_CYCLES cycles of RUN entry, set `timeout`=1 and enter DUMP as if `stop` arrived.
- Undefined: no counter, RUN waits for `stop` indefinitely, `timeout` tied 0.

## Structure
- Shared package: state enum encoding, ADDR_WIDTH/DATA_WIDTH defaults, timeout default.
- Sub-module `mem_host_ram`: 1W1R synchronous RAM, write-first-not, read-old-data; instanced for IM (host write / processor read) and DM (write mux: clear or processor; read mux: processor or dump by state).

## Test plan
- Reset, `go` with LOAD_LEN=4 words 0x1111..0x4444 → `start` pulse after 256 CLEAR + 4 LOAD cycles; `im_addr`=2 returns 0x3333 one cycle later.
- Processor model writes DM[5]=0xBEEF in RUN, raises `stop` → dump shows word 5 = 0xBEEF, all others 0, `done` pulses once.
- `dm_wr` driven in IDLE to DM[3]=0x1234 → ignored; dump word 3 = 0.
- `dp_ready` toggled 1-0-0-1 → each `dp_data` stable while stalled, no word skipped or duplicated, DUMP_LEN words total.
- `ld_valid` gaps and `stop` high on first RUN cycle → load order preserved, stale `stop` ignored.
- With `MEM_HOST_TIMEOUT_EN`, TIMEOUT_CYCLES=16, `stop` never raised → `timeout`=1 at RUN cycle 16, dump proceeds; `rst` mid-DUMP → IDLE, `dp_valid`=0 next cycle.
